// File: rtl/signal_mux_adc_n.sv
// signal_mux_adc_n: selects one real and one imaginary sample source from a
// packed multi-channel ADC bus (or a 2-bit imitator) with output blanking on
// every source switch.
//
// Optional feature macro: SIGNAL_MUX_SWCNT_EN (enables the completed-switch
// counter on sw_cnt; when undefined sw_cnt is tied to 0).
//
// Ports:
//   pclk, reset_n       clock (rising edge), async active-low reset
//   adc_re_in/adc_im_in packed channel samples, channel k at [k*DW +: DW]
//   imi_in              imitator sample, zero-extended when selected
//   sel_re/sel_im       requested source codes (0 / >NUM_CH = imitator)
//   sel_wr              strobe capturing sel_re/sel_im
//   busy                blanking in progress
//   sw_done             one-cycle pulse when a selection becomes active
//   signal_out_re/_im   registered selected samples
//   sw_cnt              completed-switch counter
module signal_mux_adc_n #(
  parameter int unsigned NUM_CH    = 12,
  parameter int unsigned DW        = 4,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic                 pclk,
  input  logic                 reset_n,
  input  logic [NUM_CH*DW-1:0] adc_re_in,
  input  logic [NUM_CH*DW-1:0] adc_im_in,
  input  logic [1:0]           imi_in,
  input  logic [4:0]           sel_re,
  input  logic [4:0]           sel_im,
  input  logic                 sel_wr,
  output logic                 busy,
  output logic                 sw_done,
  output logic [DW-1:0]        signal_out_re,
  output logic [DW-1:0]        signal_out_im,
  output logic [15:0]          sw_cnt
);

  localparam int unsigned SW = 5;
  localparam int unsigned CW = 8;
  localparam logic        BLANK_EN = (BLANK_CYC != 0);

  typedef enum logic {ST_IDLE, ST_BLANK} state_t;

  state_t        state;
  logic [SW-1:0] act_re, act_im;
  logic [SW-1:0] pend_re, pend_im;
  logic [CW-1:0] blank_cnt;
  logic          differ;
  logic          blank_req;
`ifdef SIGNAL_MUX_SWCNT_EN
  logic          pend_chg;
`endif

  // Source decode: codes 1..NUM_CH pick channel code-1, anything else the imitator.
  function automatic logic [DW-1:0] pick(input logic [SW-1:0]        code,
                                         input logic [NUM_CH*DW-1:0] bus,
                                         input logic [1:0]           imi);
    logic [DW-1:0] r;
    r = DW'(imi);
    for (int k = 0; k < NUM_CH; k++) begin
      if (code == SW'(k + 1)) r = bus[k*DW +: DW];
    end
    return r;
  endfunction

  assign differ    = ({sel_re, sel_im} != {act_re, act_im});
  // A write keeps (or starts) blanking when one is running or the pair changes.
  assign blank_req = BLANK_EN && (busy || differ);

  // Selection FSM, blank counter and registered outputs.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      act_re        <= '0;
      act_im        <= '0;
      pend_re       <= '0;
      pend_im       <= '0;
      blank_cnt     <= '0;
      busy          <= 1'b0;
      sw_done       <= 1'b0;
      signal_out_re <= '0;
      signal_out_im <= '0;
`ifdef SIGNAL_MUX_SWCNT_EN
      pend_chg      <= 1'b0;
      sw_cnt        <= '0;
`endif
    end else begin
      sw_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          signal_out_re <= pick(act_re, adc_re_in, imi_in);
          signal_out_im <= pick(act_im, adc_im_in, imi_in);
          if (sel_wr) begin
            // Same pair still commits one edge later, just without blanking.
            pend_re   <= sel_re;
            pend_im   <= sel_im;
            blank_cnt <= differ ? CW'(BLANK_CYC) : '0;
            busy      <= BLANK_EN && differ;
            state     <= ST_BLANK;
`ifdef SIGNAL_MUX_SWCNT_EN
            pend_chg  <= differ;
`endif
          end
        end
        ST_BLANK: begin
          if (sel_wr) begin
            // Last writer wins; blanking restarts from the full length.
            pend_re       <= sel_re;
            pend_im       <= sel_im;
            blank_cnt     <= blank_req ? CW'(BLANK_CYC) : '0;
            busy          <= blank_req;
            signal_out_re <= blank_req ? '0 : pick(act_re, adc_re_in, imi_in);
            signal_out_im <= blank_req ? '0 : pick(act_im, adc_im_in, imi_in);
`ifdef SIGNAL_MUX_SWCNT_EN
            pend_chg      <= differ;
`endif
          end else if (blank_cnt == '0) begin
            act_re        <= pend_re;
            act_im        <= pend_im;
            signal_out_re <= pick(pend_re, adc_re_in, imi_in);
            signal_out_im <= pick(pend_im, adc_im_in, imi_in);
            busy          <= 1'b0;
            sw_done       <= 1'b1;
            state         <= ST_IDLE;
`ifdef SIGNAL_MUX_SWCNT_EN
            if (pend_chg && sw_cnt != 16'hFFFF) sw_cnt <= sw_cnt + 16'd1;
`endif
          end else begin
            blank_cnt     <= blank_cnt - CW'(1);
            signal_out_re <= '0;
            signal_out_im <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SIGNAL_MUX_SWCNT_EN
  assign sw_cnt = 16'h0000;
`endif

endmodule
